// File: rtl/bitty_prog_loader.sv
// bitty_prog_loader: receives a program over a 4-phase strobe/ack byte handshake,
// packs byte pairs into 16-bit words, and writes them sequentially into instruction memory.
`default_nettype none

module bitty_prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_stb,
  output logic              byte_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0]   MAX_WORDS = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_HI = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  logic            stb_s1, stb_s2, stb_s3;
  logic [ADDR_W:0] target;
  logic            stb_rise;
  logic            capture;
  logic [ADDR_W:0] clamped_words;
  logic [ADDR_W:0] written_next;

  assign stb_rise      = stb_s2 & ~stb_s3;
  assign capture       = stb_rise && (state == S_WAIT_HI || state == S_WAIT_LO);
  assign clamped_words = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign written_next  = words_written + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      stb_s1        <= 1'b0;
      stb_s2        <= 1'b0;
      stb_s3        <= 1'b0;
      target        <= '0;
      byte_ack      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
      words_written <= '0;
    end else begin
      stb_s1 <= byte_stb;
      stb_s2 <= stb_s1;
      stb_s3 <= stb_s2;
      mem_we <= 1'b0;

      // Ack is held until the host's strobe drop has crossed the synchronizer.
      if (capture)
        byte_ack <= 1'b1;
      else if (!stb_s2)
        byte_ack <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mem_addr      <= '0;
            words_written <= '0;
            if (num_words == '0) begin
              load_busy <= 1'b0;
              load_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              target    <= clamped_words;
              load_busy <= 1'b1;
              load_done <= 1'b0;
              state     <= S_WAIT_HI;
            end
          end
        end
        S_WAIT_HI: begin
          if (stb_rise) begin
            mem_wdata[DATA_W-1 -: 8] <= byte_in;
            state                    <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (stb_rise) begin
            mem_wdata[7:0] <= byte_in;
            mem_we         <= 1'b1;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_written <= written_next;
          // The address saturates at the top word instead of wrapping to 0.
          if (mem_addr != LAST_ADDR)
            mem_addr <= mem_addr + 1'b1;
          if (written_next == target) begin
            load_busy <= 1'b0;
            load_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_WAIT_HI;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitty_prog_loader.sv
// Self-checking bench for bitty_prog_loader: table-driven and random loads against a word-packing model.
`default_nettype none

module tb_bitty_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_stb;
  logic        byte_ack;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        load_busy;
  logic        load_done;
  logic [8:0]  words_written;

  bitty_prog_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_stb(byte_stb), .byte_ack(byte_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_busy(load_busy), .load_done(load_done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int nw;
    int exp_cnt;
    int exp_addr;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] bq[$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: records every memory write, and flags back-to-back write enables.
  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back('{addr: mem_addr, data: mem_wdata});
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = n[8:0];
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic we_at_ack);
    int i;
    byte_in  = b;
    byte_stb = 1'b1;
    for (i = 0; i < 40 && !byte_ack; i++) tick();
    we_at_ack = mem_we;
    if (!byte_ack) check("ack_rise_timeout", {31'd0, byte_ack}, 32'd1);
    byte_stb = 1'b0;
    for (i = 0; i < 40 && byte_ack; i++) tick();
    if (byte_ack) check("ack_fall_timeout", {31'd0, byte_ack}, 32'd0);
    tick();
  endtask

  task automatic send_ignored(input logic [7:0] b, input string name);
    logic seen;
    seen     = 1'b0;
    byte_in  = b;
    byte_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); seen |= byte_ack; end
    byte_stb = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= byte_ack; end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  task automatic send_bq(input int from, input int to);
    logic w;
    for (int i = from; i < to; i++) send_byte(bq[i], w);
  endtask

  function automatic int model_cnt(input int n);
    return (n > 256) ? 256 : n;
  endfunction

  // Reference: word k of the load is bytes 2k (high) and 2k+1 (low), written at address k.
  task automatic check_writes(input int first, input int cnt, input string tag);
    check({tag, "_nwrites"}, wq.size(), cnt);
    for (int k = 0; k < cnt && k < wq.size(); k++) begin
      check({tag, "_addr"}, {24'd0, wq[k].addr}, k);
      check({tag, "_data"}, {16'd0, wq[k].data}, {16'd0, bq[2*(first+k)], bq[2*(first+k)+1]});
    end
  endtask

  task automatic run_load(input int n, input string tag);
    int cnt;
    cnt = model_cnt(n);
    bq.delete();
    for (int i = 0; i < 2*cnt; i++) bq.push_back(8'($urandom));
    wq.delete();
    do_start(n);
    check({tag, "_busy_start"}, {31'd0, load_busy}, (n != 0) ? 32'd1 : 32'd0);
    send_bq(0, 2*cnt);
    repeat (3) tick();
    check_writes(0, cnt, tag);
    check({tag, "_words"}, {23'd0, words_written}, cnt);
    check({tag, "_addr_end"}, {24'd0, mem_addr}, (cnt == 256) ? 255 : cnt);
    check({tag, "_done"}, {30'd0, load_done, load_busy}, 32'd2);
  endtask

  initial begin
    vec_t vecs[4];
    logic w;

    vecs[0] = '{nw: 2, exp_cnt: 2, exp_addr: 2};
    vecs[1] = '{nw: 1, exp_cnt: 1, exp_addr: 1};
    vecs[2] = '{nw: 3, exp_cnt: 3, exp_addr: 3};
    vecs[3] = '{nw: 5, exp_cnt: 5, exp_addr: 5};

    reset = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_stb = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {byte_ack, mem_we, mem_addr, mem_wdata, load_busy, load_done}, 32'd0);
    check("reset_words", {23'd0, words_written}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed first load: 0x12,0x34,0xAB,0xCD; write must coincide with the low-byte ack.
    bq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    wq.delete();
    do_start(2);
    check("first_busy", {30'd0, load_busy, load_done}, 32'd2);
    send_byte(8'h12, w);
    send_byte(8'h34, w);
    check("first_lat_we", {31'd0, w}, 32'd1);
    send_byte(8'hAB, w);
    send_byte(8'hCD, w);
    repeat (3) tick();
    check_writes(0, 2, "first");
    check("first_words", {23'd0, words_written}, 32'd2);
    check("first_done", {30'd0, load_done, load_busy}, 32'd2);

    // Zero-length load after a real one.
    wq.delete();
    do_start(0);
    check("zero_done", {30'd0, load_done, load_busy}, 32'd2);
    check("zero_words", {23'd0, words_written}, 32'd0);
    send_ignored(8'h77, "zero_ack_ignored");
    check("zero_nwrites", wq.size(), 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].nw, "table");
      check("table_cnt", {23'd0, words_written}, vecs[v].exp_cnt);
      check("table_addr", {24'd0, mem_addr}, vecs[v].exp_addr);
    end

    for (int r = 0; r < 6; r++) run_load($urandom_range(1, 7), "random");

    // Long strobe: exactly one capture, ack drops three clocks after strobe falls.
    bq = '{8'h5A, 8'h3C};
    wq.delete();
    do_start(1);
    byte_in = 8'h5A; byte_stb = 1'b1;
    repeat (20) tick();
    check("hold_ack_high", {31'd0, byte_ack}, 32'd1);
    byte_stb = 1'b0;
    tick(); tick();
    check("hold_ack_2clk", {31'd0, byte_ack}, 32'd1);
    tick();
    check("hold_ack_3clk", {31'd0, byte_ack}, 32'd0);
    check("hold_no_write", wq.size(), 32'd0);
    send_byte(8'h3C, w);
    repeat (3) tick();
    check_writes(0, 1, "hold");

    // Reset mid-word after the high byte, then a clean one-word load.
    wq.delete();
    do_start(2);
    send_byte(8'hFF, w);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {byte_ack, mem_we, mem_addr, mem_wdata, load_busy, load_done}, 32'd0);
    check("midreset_words", {23'd0, words_written}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    bq = '{8'h00, 8'h01};
    wq.delete();
    do_start(1);
    send_bq(0, 2);
    repeat (3) tick();
    check_writes(0, 1, "postreset");

    // Start mid-load is ignored; start in DONE begins again at address 0.
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    wq.delete();
    do_start(3);
    send_bq(0, 2);
    tick();
    do_start(1);
    check("midstart_busy", {30'd0, load_busy, load_done}, 32'd2);
    send_bq(2, 6);
    repeat (3) tick();
    check_writes(0, 3, "midstart");
    check("midstart_done", {30'd0, load_done, load_busy}, 32'd2);
    wq.delete();
    do_start(1);
    check("restart_state", {22'd0, words_written, load_busy}, 32'd1);
    send_bq(6, 8);
    repeat (3) tick();
    check_writes(3, 1, "restart");

    // Oversized request clamps to the full memory; the address saturates at 255.
    run_load(300, "full");
    wq.delete();
    send_ignored(8'h99, "full_ack_ignored");
    check("full_no_extra", wq.size(), 32'd0);
    check("full_addr_hold", {24'd0, mem_addr}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
